// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin arbiter that funnels NUM_REQ requester write
// beats into a single one-entry output stage feeding the register-bank write
// decode. Optional feature macro: RR_ARB_LOCK_EN (adds req_lock, lets the
// granted requester keep exclusive ownership across several beats).
//
// state | meaning
// ------+--------------------------------------------------------------
// EMPTY | output stage holds no beat, out_valid=0, any candidate accepted
// FULL  | output stage holds a beat, out_valid=1, accept only if out_ready
module reg_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int WORD_WIDTH = 32,
  parameter int SRC_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                          clock,
  input  logic                          areset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*WORD_WIDTH-1:0] req_data,
`ifdef RR_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]            req_lock,
`endif
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ADDR_WIDTH-1:0]         out_addr,
  output logic [WORD_WIDTH-1:0]         out_data,
  output logic [SRC_WIDTH-1:0]          out_src
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [SRC_WIDTH-1:0] ptr;
  logic [SRC_WIDTH-1:0] ptr_next;
  logic [SRC_WIDTH-1:0] cand;
  logic                 cand_found;
  logic                 accept;
  logic [NUM_REQ-1:0]   eligible;

`ifdef RR_ARB_LOCK_EN
  logic                 lock_set;
  logic [SRC_WIDTH-1:0] lock_owner;

  // While a lock is held only the owner may compete.
  always_comb begin
    eligible = req_valid;
    if (lock_set) begin
      eligible             = '0;
      eligible[lock_owner] = req_valid[lock_owner];
    end
  end

  // Lock follows the req_lock bit of every accepted beat; only the owner can
  // be accepted while locked, so its unlocked beat is what releases it.
  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      lock_set   <= 1'b0;
      lock_owner <= '0;
    end else if (accept) begin
      lock_set   <= req_lock[cand];
      lock_owner <= cand;
    end
  end
`else
  // Pure round-robin: every valid requester competes.
  always_comb begin
    eligible = req_valid;
  end
`endif

  // First eligible requester at or after ptr, wrapping; scanning the offsets
  // downward lets the smallest offset overwrite and win.
  always_comb begin
    cand_found = 1'b0;
    cand       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (eligible[(int'(ptr) + k) % NUM_REQ]) begin
        cand_found = 1'b1;
        cand       = SRC_WIDTH'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

  // Accept needs room in the output stage; reset also blocks any grant so a
  // requester never sees ready while the block is held in reset.
  always_comb begin
    accept = cand_found && areset_n && ((state == EMPTY) || out_ready);
  end

  // One-hot ready for the accepted requester only.
  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[cand] = 1'b1;
    end
  end

  // Pointer advances past the accepted requester, wrapping at NUM_REQ-1.
  always_comb begin
    ptr_next = ptr;
    if (accept) begin
      if (int'(cand) == NUM_REQ - 1) begin
        ptr_next = '0;
      end else begin
        ptr_next = cand + SRC_WIDTH'(1);
      end
    end
  end

  // Output-stage state and round-robin pointer registers.
  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      state <= EMPTY;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  // Next-state and out_valid decode for the output stage.
  always_comb begin
    state_next = state;
    out_valid  = (state == FULL);
    case (state)
      EMPTY: begin
        if (accept) begin
          state_next = FULL;
        end
      end
      FULL: begin
        if (accept) begin
          state_next = FULL;
        end else if (out_ready) begin
          state_next = EMPTY;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

  // Capture the accepted beat; fields hold after the bank drains it.
  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      out_addr <= '0;
      out_data <= '0;
      out_src  <= '0;
    end else if (accept) begin
      out_addr <= req_addr[int'(cand) * ADDR_WIDTH +: ADDR_WIDTH];
      out_data <= req_data[int'(cand) * WORD_WIDTH +: WORD_WIDTH];
      out_src  <= cand;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed vector table, hand-written reset and
// lock sequences, then protocol-respecting random traffic against a
// behavioural model of the arbitration rules.
module tb_reg_write_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int WW = 32;

  logic            clock;
  logic            areset_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*WW-1:0] req_data;
`ifdef RR_ARB_LOCK_EN
  logic [N-1:0]    req_lock;
`endif
  logic            out_valid;
  logic            out_ready;
  logic [AW-1:0]   out_addr;
  logic [WW-1:0]   out_data;
  logic [1:0]      out_src;

  int checks = 0;
  int errors = 0;

  reg_write_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .WORD_WIDTH(WW)) dut (
    .clock     (clock),
    .areset_n  (areset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
`ifdef RR_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .out_src   (out_src)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [N-1:0] valid;
    logic         ordy;
    logic [N-1:0] exp_ready;
    logic         exp_valid;
    logic [1:0]   exp_src;
  } vec_t;

  vec_t tbl[21];

  // behavioural model state
  bit          m_full;
  int          m_ptr;
  logic [7:0]  m_addr;
  logic [31:0] m_data;
  int          m_src;
  bit          m_lock;
  int          m_owner;

  // pending beats of the random requesters
  bit          pend[N];
  logic [7:0]  pa[N];
  logic [31:0] pd[N];
  bit          pl[N];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] dir_addr(input int i);
    return (i == 1) ? 8'h12 : 8'(8'h40 + i);
  endfunction

  function automatic logic [31:0] dir_data(input int i);
    return (i == 1) ? 32'hDEAD_BEEF : 32'(32'hA000_0000 + i);
  endfunction

  task automatic load_directed();
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = dir_addr(i);
      req_data[i*WW +: WW] = dir_data(i);
    end
  endtask

  // Drive one cycle of directed stimulus, check ready before the edge and
  // the captured output after it.
  task automatic step(input string nm, input logic [N-1:0] v, input logic ordy,
                      input logic [N-1:0] e_rdy, input logic e_val, input int e_src);
    @(negedge clock);
    req_valid = v;
    out_ready = ordy;
    #1;
    chk({nm, ".req_ready"}, 32'(req_ready), 32'(e_rdy));
    @(posedge clock);
    #1;
    chk({nm, ".out_valid"}, 32'(out_valid), 32'(e_val));
    chk({nm, ".out_src"},   32'(out_src),   32'(e_src));
    chk({nm, ".out_addr"},  32'(out_addr),  32'(dir_addr(e_src)));
    chk({nm, ".out_data"},  out_data,       dir_data(e_src));
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({nm, ".out_addr"},  32'(out_addr),  32'd0);
    chk({nm, ".out_data"},  out_data,       32'd0);
    chk({nm, ".out_src"},   32'(out_src),   32'd0);
    chk({nm, ".req_ready"}, 32'(req_ready), 32'd0);
  endtask

  // Grant decision from the rules: who may go, scanned from ptr with wrap.
  function automatic int model_pick(input bit v[N]);
    if (m_full && !out_ready) return -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (v[i] && (!m_lock || i == m_owner)) return i;
    end
    return -1;
  endfunction

  task automatic reset_model();
    m_full = 0; m_ptr = 0; m_addr = '0; m_data = '0; m_src = 0;
    m_lock = 0; m_owner = 0;
    for (int i = 0; i < N; i++) pend[i] = 0;
  endtask

  initial begin
    areset_n  = 1'b0;
    req_valid = '0;
    out_ready = 1'b0;
`ifdef RR_ARB_LOCK_EN
    req_lock  = '0;
`endif
    load_directed();

    // cycle-by-cycle vectors after reset (ptr=0, EMPTY)
    tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[5]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[6]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1};
    tbl[7]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd1};
    tbl[8]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2};
    tbl[9]  = '{4'b0101, 1'b0, 4'b0000, 1'b1, 2'd2};
    tbl[10] = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[11] = '{4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[12] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2};
    tbl[13] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[14] = '{4'b0100, 1'b0, 4'b0000, 1'b1, 2'd1};
    tbl[15] = '{4'b0100, 1'b0, 4'b0000, 1'b1, 2'd1};
    tbl[16] = '{4'b0100, 1'b0, 4'b0000, 1'b1, 2'd1};
    tbl[17] = '{4'b0100, 1'b0, 4'b0000, 1'b1, 2'd1};
    tbl[18] = '{4'b0100, 1'b0, 4'b0000, 1'b1, 2'd1};
    tbl[19] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[20] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2};

    #1;
    check_reset_outputs("reset");
    #11;
    areset_n = 1'b1;

    for (int t = 0; t < 21; t++) begin
      step($sformatf("vec%0d", t), tbl[t].valid, tbl[t].ordy,
           tbl[t].exp_ready, tbl[t].exp_valid, int'(tbl[t].exp_src));
    end

    // reset while FULL and stalled
    step("fill", 4'b0001, 1'b0, 4'b0001, 1'b1, 0);
    @(negedge clock);
    req_valid = 4'b0001;
    out_ready = 1'b0;
    #2;
    areset_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(posedge clock);
    #1;
    areset_n = 1'b1;
    step("post_reset", 4'b1000, 1'b0, 4'b1000, 1'b1, 3);

    // pointer must restart at 0 after reset
    step("ptr_move", 4'b0010, 1'b1, 4'b0010, 1'b1, 1);
    @(negedge clock);
    req_valid = '0;
    areset_n  = 1'b0;
    #1;
    check_reset_outputs("ptr_reset");
    @(posedge clock);
    #1;
    areset_n = 1'b1;
    step("ptr_zero", 4'b1111, 1'b1, 4'b0001, 1'b1, 0);
    step("drain", 4'b0000, 1'b1, 4'b0000, 1'b0, 0);

`ifdef RR_ARB_LOCK_EN
    step("lk_pre", 4'b0001, 1'b1, 4'b0001, 1'b1, 0);
    req_lock = 4'b0010;
    step("lk_a", 4'b0111, 1'b1, 4'b0010, 1'b1, 1);
    step("lk_b", 4'b0111, 1'b1, 4'b0010, 1'b1, 1);
    req_lock = 4'b0000;
    step("lk_c", 4'b0111, 1'b1, 4'b0010, 1'b1, 1);
    step("lk_d", 4'b0101, 1'b1, 4'b0100, 1'b1, 2);
    step("lk_e", 4'b0001, 1'b1, 4'b0001, 1'b1, 0);
    step("lk_f", 4'b0000, 1'b1, 4'b0000, 1'b0, 0);
`endif

    // randomized traffic against the model
    @(negedge clock);
    req_valid = '0;
    areset_n  = 1'b0;
    @(posedge clock);
    #1;
    areset_n = 1'b1;
    reset_model();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int g;
      logic [N-1:0] e_rdy;
      @(negedge clock);
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i] = 1;
          pa[i]   = 8'($urandom);
          pd[i]   = $urandom;
          pl[i]   = ($urandom_range(0, 2) == 0);
        end
        req_valid[i]         = pend[i];
        req_addr[i*AW +: AW] = pend[i] ? pa[i] : 8'($urandom);
        req_data[i*WW +: WW] = pend[i] ? pd[i] : $urandom;
`ifdef RR_ARB_LOCK_EN
        req_lock[i]          = pend[i] ? pl[i] : 1'($urandom);
`endif
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      g = model_pick(pend);
      e_rdy = '0;
      if (g >= 0) e_rdy[g] = 1'b1;
      chk("rnd.req_ready", 32'(req_ready), 32'(e_rdy));
      @(posedge clock);
      if (g >= 0) begin
        m_full = 1;
        m_addr = pa[g];
        m_data = pd[g];
        m_src  = g;
        m_ptr  = (g + 1) % N;
`ifdef RR_ARB_LOCK_EN
        m_lock  = pl[g];
        m_owner = g;
`endif
        pend[g] = 0;
      end else if (m_full && out_ready) begin
        m_full = 0;
      end
      #1;
      chk("rnd.out_valid", 32'(out_valid), 32'(m_full));
      chk("rnd.out_addr",  32'(out_addr),  32'(m_addr));
      chk("rnd.out_data",  out_data,       m_data);
      chk("rnd.out_src",   32'(out_src),   32'(m_src));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin arbiter that shares the single write port of a configuration register bank between NUM_REQ requesters (management interface, per-port MAC controllers, learning engine). Each requester presents an address/data write beat with a valid/ready handshake; the block selects one, captures it into a one-entry output stage and drives it toward the register bank with its own valid/ready handshake. It sits between the requesters and the register-bank write decode, and supplies the per-register clock_enable/data_in through that decode.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- ADDR_WIDTH, 8, register address width
- WORD_WIDTH, 32, register data width
- SRC_WIDTH, clog2(NUM_REQ), width of out_src (derived, not overridden)

Ports:
- clock  in  1  single clock, all logic on posedge
- areset_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  request beat present, one bit per requester
- req_ready  out  NUM_REQ  beat accepted this cycle, one-hot or zero
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_data  in  NUM_REQ*WORD_WIDTH  packed write data, same packing
- req_lock  in  NUM_REQ  hold grant after this beat (present only with RR_ARB_LOCK_EN)
- out_valid  out  1  output beat valid
- out_ready  in  1  register bank consumes beat
- out_addr  out  ADDR_WIDTH  captured address
- out_data  out  WORD_WIDTH  captured data
- out_src  out  SRC_WIDTH  index of requester that issued the beat

## Operation
- State machine on the output stage: EMPTY (out_valid=0), FULL (out_valid=1).
- Arbitration (combinational): candidate = first i with req_valid[i]=1, searching from ptr upward, wrapping NUM_REQ-1 → 0.
- Accept condition: candidate exists AND (EMPTY OR out_ready=1). On accept, req_ready[candidate]=1 for that cycle, and all other req_ready bits are 0.
- On accept: out_addr/out_data/out_src ← candidate's fields; state ← FULL; ptr ← (candidate+1) mod NUM_REQ.
- FULL with out_ready=1 and no accept: state ← EMPTY; out_addr/out_data/out_src hold their values.
- FULL with out_ready=1 and accept: state stays FULL with new beat (back-to-back, one beat per cycle).
- FULL with out_ready=0: no accept, and all outputs stable.
- Requesters must hold valid/addr/data until ready. The block never deasserts out_valid without out_ready.
- Requests with req_valid=0 are never granted, whatever their addr/data.

## Timing
- Reset (areset_n=0, any time, including mid-transfer): state EMPTY, out_valid=0, out_addr=0, out_data=0, out_src=0, ptr=0, lock cleared, req_ready=0. Any in-flight beat is discarded.
- Reset release: the first accept is possible on the first posedge after areset_n rises.
- Latency: beat accepted at edge N gives out_valid=1 with its data after edge N (visible in cycle N+1).
- req_ready is combinational from req_valid, ptr, state and out_ready. There is no combinational path from req_addr/req_data to any output.
- Throughput: 1 beat/cycle while out_ready=1. Fairness: each continuously requesting source is granted at least once every NUM_REQ accepts.
- Pointer wrap: candidate NUM_REQ-1 gives ptr=0.

## Configuration
- RR_ARB_LOCK_EN defined:
  - The req_lock port exists.
  - When a beat is accepted with req_lock[i]=1, the lock is set with owner i.
  - While the lock is set, only owner i is eligible; other req_valid bits are ignored.
  - The lock clears on acceptance of owner i's beat with req_lock[i]=0.
  - ptr updates normally on each accept.
- RR_ARB_LOCK_EN undefined: the req_lock port is absent, and arbitration is pure round-robin.

## Test plan
- Reset mid-transfer: FULL with out_ready=0, assert areset_n=0 → out_valid=0, out_addr=0, out_src=0, ptr=0 immediately. After release, req_valid=4'b1000 → src 3 granted.
- All four requesting continuously, out_ready=1, after reset → out_src sequence 0,1,2,3,0,1, one beat per cycle, with req_ready one-hot each cycle.
- Backpressure: req_valid=4'b0010, addr 0x12, data 0xDEADBEEF, out_ready=0 for 5 cycles → out_valid=1 and outputs stable; req_valid=4'b0100 sees req_ready=0 throughout. When out_ready=1, requester 2 is accepted in the same cycle.
- Wrap and skip: ptr=3, req_valid=4'b0101 → requester 0 granted, then ptr=1 → requester 2 granted next.
- Idle drain: one beat accepted, then req_valid=0, out_ready=1 → out_valid=1 for exactly one cycle, then EMPTY.
- RR_ARB_LOCK_EN: requester 1 sends 3 beats with req_lock=1,1,0 while requesters 0 and 2 are also valid → out_src=1,1,1, then 2, then 0.
